// File: rtl/mac_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mac_pkg : shared operand type, feeder states and latency of the signed MAC
// Rev 1.0
// ----------------------------------------------------------------------------
package mac_pkg;

    localparam int c_WIDTH   = 10;
    localparam int c_DEPTH   = 8;
    localparam int c_MAC_LAT = 2;

    typedef logic signed [c_WIDTH-1:0] operand_t;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_operand_feeder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mac_operand_feeder_if : producer handshake and MAC-side operand bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface mac_operand_feeder_if
    import mac_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
);
    logic signed [WIDTH-1:0] in_a;
    logic signed [WIDTH-1:0] in_b;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic                    valid_in;
    logic                    mac_clear;
    logic                    dot_done;
    logic                    busy;

    modport slave (
        input  in_a, in_b, in_valid, in_last,
        output in_ready, a, b, valid_in, mac_clear, dot_done, busy
    );

    modport master (
        output in_a, in_b, in_valid, in_last,
        input  in_ready, a, b, valid_in, mac_clear, dot_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/mac_operand_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mac_operand_buf : DEPTH-entry operand-pair register file, sync write/comb read
// Rev 1.0
// ----------------------------------------------------------------------------
module mac_operand_buf
    import mac_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int DEPTH = c_DEPTH
) (
    input  wire logic                         clk,
    input  wire logic                         we_i,
    input  wire logic [$clog2(DEPTH)-1:0]     waddr_i,
    input  wire logic signed [WIDTH-1:0]      wa_i,
    input  wire logic signed [WIDTH-1:0]      wb_i,
    input  wire logic [$clog2(DEPTH)-1:0]     raddr_i,
    output logic signed [WIDTH-1:0]           ra_o,
    output logic signed [WIDTH-1:0]           rb_o
);
    logic [2*WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= {wa_i, wb_i};
        end
    end

    assign ra_o = mem_q[raddr_i][2*WIDTH-1:WIDTH];
    assign rb_o = mem_q[raddr_i][WIDTH-1:0];
endmodule
`default_nettype wire

// File: rtl/mac_operand_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mac_operand_feeder : buffers one vector of (a,b) pairs, then clears and feeds the MAC
// Rev 1.0
// ----------------------------------------------------------------------------
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int WIDTH   = c_WIDTH,
    parameter int DEPTH   = c_DEPTH,
    parameter int MAC_LAT = c_MAC_LAT
) (
    input  wire logic           clk,
    input  wire logic           reset,
    mac_operand_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(MAC_LAT) + 1;

    feeder_state_t           state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           drain_q, drain_d;
    logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                    valid_q, valid_d;
    logic                    xfer;
    logic signed [WIDTH-1:0] rd_a, rd_b;

    assign xfer = bus.in_valid && (state_q == LOAD);

    mac_operand_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .we_i    (xfer),
        .waddr_i (count_q[AW-1:0]),
        .wa_i    (bus.in_a),
        .wb_i    (bus.in_b),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .ra_o    (rd_a),
        .rb_o    (rd_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= LOAD;
            count_q  <= '0;
            rd_ptr_q <= '0;
            drain_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            drain_q  <= drain_d;
            a_q      <= a_d;
            b_q      <= b_d;
            valid_q  <= valid_d;
        end
    end

    // rd_ptr runs one ahead of the pair on a/b, so STREAM ends when it reaches N.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        drain_d  = drain_q;
        a_d      = a_q;
        b_d      = b_q;
        valid_d  = valid_q;
        case (state_q)
            LOAD: begin
                if (xfer) begin
                    count_d = count_q + CW'(1);
                    if (bus.in_last || (count_q == CW'(DEPTH - 1))) begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                a_d      = rd_a;
                b_d      = rd_b;
                valid_d  = 1'b1;
                rd_ptr_d = rd_ptr_q + CW'(1);
                state_d  = STREAM;
            end
            STREAM: begin
                if (rd_ptr_q == count_q) begin
                    valid_d = 1'b0;
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    a_d      = rd_a;
                    b_d      = rd_b;
                    rd_ptr_d = rd_ptr_q + CW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == LW'(MAC_LAT - 1)) begin
                    count_d  = '0;
                    rd_ptr_d = '0;
                    state_d  = LOAD;
                end else begin
                    drain_d = drain_q + LW'(1);
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.busy      = (state_q != LOAD);
    assign bus.mac_clear = (state_q == CLEAR);
    assign bus.dot_done  = (state_q == DRAIN) && (drain_q == LW'(MAC_LAT - 1));
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.valid_in  = valid_q;
endmodule
`default_nettype wire

// File: tb/tb_mac_operand_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mac_operand_feeder : random vectors against a cycle-schedule scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mac_operand_feeder;
    import mac_pkg::*;

    localparam int W = c_WIDTH;
    localparam int D = c_DEPTH;
    localparam int L = c_MAC_LAT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_operand_feeder_if #(.WIDTH(W)) bus ();

    mac_operand_feeder #(.WIDTH(W), .DEPTH(D), .MAC_LAT(L)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ready_cyc = 0;
    int last_k   = 0;

    int pq_a[$], pq_b[$], pq_c[$];
    int clr_q[$];
    int dot_c[$], dot_s[$];

    logic signed [W-1:0] va [D];
    logic signed [W-1:0] vb [D];
    int                  gp [D];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fill_random(input bit gaps);
        for (int i = 0; i < D; i++) begin
            va[i] = W'($urandom);
            vb[i] = W'($urandom);
            gp[i] = gaps ? int'($urandom_range(0, 2)) : 0;
        end
    endtask

    // Cycle k is the one that starts at the edge of the last transfer; from the
    // block's rules, k is CLEAR, k+1..k+n carry the pairs, k+n+L is dot_done.
    task automatic send_vec(input int n, input bit use_last);
        int sum;
        int k;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gp[i]; g++) begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'($urandom);
                bus.in_a     = W'($urandom);
                bus.in_b     = W'($urandom);
                chk("in_ready_gap", bus.in_ready, cyc >= ready_cyc);
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_a     = va[i];
            bus.in_b     = vb[i];
            bus.in_last  = use_last && (i == n - 1);
            for (int t = 0; ; t++) begin
                chk("in_ready", bus.in_ready, cyc >= ready_cyc);
                if (bus.in_ready) break;
                if (t > 200) begin
                    $display("FAIL in_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
                    $fatal(1, "in_ready never returned");
                end
                @(negedge clk);
            end
            k = cyc + 1;
            sum += va[i] * vb[i];
            if (i == n - 1) begin
                clr_q.push_back(k);
                for (int j = 0; j < n; j++) begin
                    pq_a.push_back(int'(va[j]));
                    pq_b.push_back(int'(vb[j]));
                    pq_c.push_back(k + 1 + j);
                end
                dot_c.push_back(k + n + L);
                dot_s.push_back(sum);
                ready_cyc = k + n + L + 1;
                last_k    = k;
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an output event.
    initial begin : monitor
        int  acc;
        bit  after_dot;
        acc = 0;
        after_dot = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc = 0;
                after_dot = 0;
            end else begin
                if (after_dot) begin
                    chk("ready_after_done", bus.in_ready, 1);
                    chk("busy_after_done", bus.busy, 0);
                    after_dot = 0;
                end
                if (bus.mac_clear) begin
                    acc = 0;
                    if (clr_q.size() == 0) chk("mac_clear_unexpected", bus.mac_clear, 0);
                    else begin
                        chk("clear_cycle", cyc, clr_q.pop_front());
                        chk("ready_in_clear", bus.in_ready, 0);
                        chk("busy_in_clear", bus.busy, 1);
                    end
                end
                if (bus.valid_in) begin
                    acc += bus.a * bus.b;
                    if (pq_c.size() == 0) chk("valid_in_unexpected", bus.valid_in, 0);
                    else begin
                        chk("stream_a", bus.a, pq_a.pop_front());
                        chk("stream_b", bus.b, pq_b.pop_front());
                        chk("stream_cycle", cyc, pq_c.pop_front());
                    end
                end
                if (bus.dot_done) begin
                    if (dot_c.size() == 0) chk("dot_done_unexpected", bus.dot_done, 0);
                    else begin
                        chk("done_cycle", cyc, dot_c.pop_front());
                        chk("dot_sum", acc, dot_s.pop_front());
                        chk("valid_at_done", bus.valid_in, 0);
                        chk("ready_at_done", bus.in_ready, 0);
                        after_dot = 1;
                    end
                end
            end
        end
    end

    initial begin : driver
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        for (int i = 0; i < D; i++) gp[i] = 0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_a", bus.a, 0);
        chk("rst_b", bus.b, 0);
        chk("rst_valid_in", bus.valid_in, 0);
        chk("rst_mac_clear", bus.mac_clear, 0);
        chk("rst_dot_done", bus.dot_done, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);

        // Directed load-and-stream, then forced-last and another vector back to back.
        va[0] = 10'sd2;  vb[0] = 10'sd3;
        va[1] = -10'sd4; vb[1] = 10'sd5;
        va[2] = 10'sd7;  vb[2] = -10'sd1;
        send_vec(3, 1'b1);
        fill_random(1'b0);
        send_vec(8, 1'b0);
        fill_random(1'b0);
        send_vec(5, 1'b1);

        // Gaps between pairs: in_valid 1,0,1,0,1.
        fill_random(1'b0);
        gp[1] = 1; gp[2] = 1;
        send_vec(3, 1'b1);

        // Single-element vector at the negative extreme.
        va[0] = -10'sd512; vb[0] = -10'sd512; gp[0] = 0;
        send_vec(1, 1'b1);

        // Asynchronous reset during the second valid_in cycle.
        fill_random(1'b0);
        send_vec(4, 1'b1);
        while (cyc != last_k + 2) begin
            @(posedge clk); #2;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_valid_in", bus.valid_in, 0);
        chk("arst_mac_clear", bus.mac_clear, 0);
        chk("arst_dot_done", bus.dot_done, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_busy", bus.busy, 0);
        chk("arst_a", bus.a, 0);
        pq_a.delete(); pq_b.delete(); pq_c.delete();
        clr_q.delete(); dot_c.delete(); dot_s.delete();
        ready_cyc = 0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        fill_random(1'b0);
        send_vec(2, 1'b1);

        // Random vectors with random lengths and gaps.
        for (int v = 0; v < 12; v++) begin
            int n;
            n = int'($urandom_range(1, D));
            fill_random(1'b1);
            send_vec(n, (n < D) ? 1'b1 : 1'($urandom));
        end

        for (int t = 0; t < 300 && (pq_c.size() + dot_c.size() + clr_q.size()) != 0; t++)
            @(negedge clk);
        chk("queues_drained", pq_c.size() + dot_c.size() + clr_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
